// File: rtl/alu_seq.sv
// WIDTH-bit registered ALU with START/DONE handshake, carry-chained
// ADC/SBB, single-bit shifts and a bit-serial shift-add multiplier.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             OE,
    input  logic             START,
    input  logic [3:0]       OPCODE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic             CF,
    output logic             OF,
    output logic             SF,
    output logic             ZF,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_ADC = 4'b1010;
    localparam logic [3:0] OP_SBB = 4'b1011;
    localparam logic [3:0] OP_SHL = 4'b1100;
    localparam logic [3:0] OP_SHR = 4'b1101;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               cf_q, cf_d;
    logic               of_q, of_d;
    logic               sf_q, sf_d;
    logic               zf_q, zf_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               cin;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     dif;
    logic               add_ovf;
    logic               sub_ovf;
    logic [WIDTH-1:0]   op_res;
    logic               op_cf;
    logic               op_of;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;

    // One shared adder and subtractor; carry-in only for ADC/SBB
    always_comb begin
        cin = 1'b0;
        if (OPCODE == OP_ADC || OPCODE == OP_SBB) begin
            cin = cf_q;
        end
        sum = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};
        dif = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, cin};
        add_ovf = (A[WIDTH-1] == B[WIDTH-1]) &&
                  (sum[WIDTH-1] != A[WIDTH-1]);
        sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) &&
                  (dif[WIDTH-1] != A[WIDTH-1]);
    end

    always_comb begin
        op_res = '0;
        op_cf  = 1'b0;
        op_of  = 1'b0;
        case (OPCODE)
            OP_ADD, OP_ADC: begin
                op_res = sum[WIDTH-1:0];
                op_cf  = sum[WIDTH];
                op_of  = add_ovf;
            end
            OP_SUB, OP_SBB: begin
                op_res = dif[WIDTH-1:0];
                op_cf  = dif[WIDTH];
                op_of  = sub_ovf;
            end
            OP_AND: op_res = A & B;
            OP_OR:  op_res = A | B;
            OP_XOR: op_res = A ^ B;
            OP_NOT: op_res = ~A;
            OP_SHL: begin
                op_res = {A[WIDTH-2:0], 1'b0};
                op_cf  = A[WIDTH-1];
            end
            OP_SHR: begin
                op_res = {1'b0, A[WIDTH-1:1]};
                op_cf  = A[0];
            end
            default: begin
                op_res = '0;
                op_cf  = 1'b0;
                op_of  = 1'b0;
            end
        endcase
    end

    // Accumulator is {partial product, remaining multiplier bits}
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_step = {mul_sum, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        cf_d    = cf_q;
        of_d    = of_q;
        sf_d    = sf_q;
        zf_d    = zf_q;
        done_d  = done_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        if (EN) begin
            done_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        if (OPCODE == OP_MUL) begin
                            acc_d   = {{WIDTH{1'b0}}, B};
                            mcand_d = A;
                            cnt_d   = '0;
                            state_d = ST_MUL;
                        end else begin
                            res_d  = op_res;
                            cf_d   = op_cf;
                            of_d   = op_of;
                            sf_d   = op_res[WIDTH-1];
                            zf_d   = (op_res == '0);
                            done_d = 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    acc_d = mul_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        res_d   = mul_step[WIDTH-1:0];
                        cf_d    = |mul_step[2*WIDTH-1:WIDTH];
                        of_d    = 1'b0;
                        sf_d    = mul_step[WIDTH-1];
                        zf_d    = (mul_step[WIDTH-1:0] == '0);
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            cf_q    <= 1'b0;
            of_q    <= 1'b0;
            sf_q    <= 1'b0;
            zf_q    <= 1'b0;
            done_q  <= 1'b0;
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            cf_q    <= cf_d;
            of_q    <= of_d;
            sf_q    <= sf_d;
            zf_q    <= zf_d;
            done_q  <= done_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ALU_OUT = OE ? res_q : {WIDTH{1'bz}};
    assign CF      = cf_q;
    assign OF      = of_q;
    assign SF      = sf_q;
    assign ZF      = zf_q;
    assign BUSY    = (state_q == ST_MUL);
    assign DONE    = done_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised successor to the 8-bit lab ALU: WIDTH-bit registered ALU with a START/DONE handshake.
- Adds carry-chained ADC/SBB, single-bit shifts and a multi-cycle unsigned shift-add multiplier with a BUSY flag.
- Sits behind a simple controller or testbench that issues one operation at a time and reads ALU_OUT and the flags on DONE.

Parameters:
- WIDTH, 8, operand/result width in bits (WIDTH >= 2)

Ports:
- CLK  input  1  single clock; all state updates on the rising edge
- RST  input  1  synchronous, active-high reset
- EN  input  1  clock enable; 0 freezes all internal state, START ignored
- OE  input  1  output enable; 0 drives ALU_OUT to high-Z (flags unaffected)
- START  input  1  request, sampled when EN=1 and BUSY=0
- OPCODE  input  4  operation select, sampled with START
- A  input  WIDTH  operand A, sampled with START
- B  input  WIDTH  operand B, sampled with START
- ALU_OUT  output  WIDTH  registered result, tri-stated by OE
- CF  output  1  carry/borrow/shift-out/multiply-high-nonzero
- OF  output  1  signed overflow
- SF  output  1  result MSB
- ZF  output  1  result == 0
- BUSY  output  1  multiply in progress
- DONE  output  1  one-cycle pulse: result and flags updated

Behaviour:
- Reset (RST=1 at an edge, overrides everything): result register, CF, OF, SF, ZF, BUSY and DONE all go to 0. ALU_OUT reads 0 when OE=1. A multiply in progress is aborted.
- Opcodes:
  - 0010 ADD: A+B.
  - 0011 SUB: A-B, CF=borrow (A<B unsigned).
  - 0100 AND.
  - 0101 OR.
  - 0110 XOR.
  - 0111 NOT A.
  - 1000 MUL: unsigned, low WIDTH bits returned, CF=1 if the high WIDTH bits are nonzero, OF=0.
  - 1010 ADC: A+B+CF, using the current CF register.
  - 1011 SBB: A-B-CF, CF=borrow.
  - 1100 SHL: A<<1, CF=A[WIDTH-1].
  - 1101 SHR: logical A>>1, CF=A[0].
  - Any other opcode: result 0, CF=OF=SF=0, ZF=1, DONE still pulses.
- OF: signed two's-complement overflow for ADD/SUB/ADC/SBB. 0 for logic, shift and MUL.
- CF: 0 for logic ops.
- SF and ZF: always derived from the WIDTH-bit result.
- Single-cycle ops: START sampled at edge k. After edge k, result, flags and DONE=1 are valid. DONE drops after edge k+1 unless a new START is accepted there, which allows back-to-back issue.
- MUL:
  - START accepted at edge 0 latches the operands; BUSY=1 after edge 0.
  - Edges 1..WIDTH each process one multiplier bit (shift-add into a 2*WIDTH accumulator).
  - After edge WIDTH: BUSY=0, DONE=1, result and flags valid.
  - During BUSY, START is ignored, and ALU_OUT and the flags hold the previous result.
- EN=0: the sequencer stalls and all registers hold. DONE holds its value, so an asserted DONE is not lost. Resuming EN continues the multiply where it stopped.
- The CF register persists across operations and is the only cross-operation state.
- OE is purely combinational on ALU_OUT and does not affect internal state.

Test Plan:
- WIDTH=8 ADD A=255 B=255 -> ALU_OUT=254, CF=1, OF=0, SF=1, ZF=0, DONE pulses 1 cycle. ADD A=0x7F B=0x01 -> 0x80, OF=1, SF=1, CF=0.
- SUB A=0 B=255 -> ALU_OUT=1, CF=1. Then SBB A=5 B=2 -> 2 (uses CF=1), CF=0. ADD 0xFF+0x01 -> 0, CF=1, ZF=1, then ADC 0+0 -> 1, CF=0.
- MUL A=15 B=17 -> BUSY high for 8 edges, then ALU_OUT=255, CF=0. MUL A=16 B=16 -> 0, CF=1, ZF=1. A START with ADD issued mid-BUSY is ignored, with no extra DONE.
- SHL A=0x81 -> 0x02, CF=1. SHR A=0x01 -> 0x00, CF=1, ZF=1. OPCODE=1111 -> 0, ZF=1, CF=0.
- OE=0 at any time -> ALU_OUT=8'bz while flags keep their values. EN=0 for 3 cycles mid-MUL -> completion is delayed by exactly 3 cycles with the same result.
- RST=1 on the 4th multiply edge -> after that edge BUSY=0, DONE=0, ALU_OUT=0, all flags 0, and no late DONE follows.
